// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation controller.
//   state_t  : sequencer states
//   SEL_*    : multiplier operand-B select codes
//   DEF_*    : default widths
package rsa_pkg;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SQR_S = 3'd2,
    SQR_W = 3'd3,
    MUL_S = 3'd4,
    MUL_W = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic SEL_ACC  = 1'b0;
  localparam logic SEL_BASE = 1'b1;
endpackage

// File: rtl/rsa_bit_scan.sv
// Exponent bit scanner: latches the exponent and walks a bit index from
// WIDTH-1 down to 0.
//   clk, rstb : clock, synchronous active-low reset
//   en        : global advance enable
//   load      : latch exp_i, index <= WIDTH-1
//   dec       : step index down by one (saturates at 0)
//   exp_i     : exponent input
//   cur_bit   : exponent bit at the current index
//   last_bit  : current index is 0
module rsa_bit_scan
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] exp_i,
  output logic             cur_bit,
  output logic             last_bit
);

  logic [WIDTH-1:0] exp_q;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] exp_sh;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      exp_q <= '0;
      idx_q <= '0;
    end else if (en) begin
      if (load) begin
        exp_q <= exp_i;
        idx_q <= CNT_W'(WIDTH - 1);
      end else if (dec && (idx_q != '0)) begin
        // Guarded so the index can never wrap past zero.
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  // Shift rather than dynamic bit-select keeps the index range lint-clean.
  assign exp_sh   = exp_q >> idx_q;
  assign cur_bit  = exp_sh[0];
  assign last_bit = (idx_q == '0);

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// MSB-first square-and-multiply sequencer computing R = B^E mod N over a
// shared external modular multiplier.
//   clk, rstb          : clock, synchronous active-low reset
//   en                 : global advance enable (low freezes everything)
//   start              : request, sampled only in IDLE
//   base_i, exp_i      : operands B and E
//   busy               : not in IDLE
//   eoc, R_o           : one-cycle completion pulse and held result
//   mm_start           : one-cycle multiplier start
//   mm_a, mm_b         : multiplier operands (acc, acc|base)
//   mm_done, mm_result : multiplier completion strobe and product
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] exp_i,
  output logic             busy,
  output logic             eoc,
  output logic [WIDTH-1:0] R_o,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, base_q, r_q;
  logic             eoc_q;

  logic             scan_load, scan_dec;
  logic             acc_init, acc_upd;
  logic             issue;
  logic             sel_b;
  logic             cur_bit, last_bit;

  rsa_bit_scan #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_scan (
    .clk      (clk),
    .rstb     (rstb),
    .en       (en),
    .load     (scan_load),
    .dec      (scan_dec),
    .exp_i    (exp_i),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      r_q     <= '0;
      eoc_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      if (acc_init) begin
        acc_q  <= WIDTH'(1);
        base_q <= base_i;
      end else if (acc_upd) begin
        acc_q  <= mm_result;
      end
      // Result and pulse are launched on the same edge that leaves DONE,
      // so R_o is already valid while eoc is high.
      eoc_q <= (state_q == DONE);
      if (state_q == DONE) r_q <= acc_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    scan_load = 1'b0;
    scan_dec  = 1'b0;
    acc_init  = 1'b0;
    acc_upd   = 1'b0;
    issue     = 1'b0;
    sel_b     = SEL_ACC;
    case (state_q)
      IDLE: begin
        if (start) begin
          scan_load = 1'b1;
          acc_init  = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD:  state_d = SQR_S;
      SQR_S: begin
        issue   = 1'b1;
        state_d = SQR_W;
      end
      SQR_W: begin
        if (mm_done) begin
          acc_upd = 1'b1;
          if (cur_bit) begin
            state_d = MUL_S;       // index stays; MUL_W steps it
          end else if (last_bit) begin
            state_d = DONE;
          end else begin
            scan_dec = 1'b1;
            state_d  = SQR_S;
          end
        end
      end
      MUL_S: begin
        issue   = 1'b1;
        sel_b   = SEL_BASE;
        state_d = MUL_W;
      end
      MUL_W: begin
        sel_b = SEL_BASE;
        if (mm_done) begin
          acc_upd = 1'b1;
          if (last_bit) begin
            state_d = DONE;
          end else begin
            scan_dec = 1'b1;
            state_d  = SQR_S;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are masked while frozen; the state holds, so they reappear
  // once en returns.
  assign mm_start = issue & en;
  assign eoc      = eoc_q & en;
  assign busy     = (state_q != IDLE);
  assign R_o      = r_q;
  assign mm_a     = acc_q;
  assign mm_b     = (sel_b == SEL_BASE) ? base_q : acc_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
module tb_rsa_modexp_ctrl;
  localparam int W    = 10;
  localparam int L    = 3;
  localparam int MODN = 1009;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] base_i = '0;
  logic [W-1:0] exp_i = '0;
  logic         busy, eoc, mm_start, mm_done;
  logic [W-1:0] R_o, mm_a, mm_b, mm_result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rsa_modexp_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .start     (start),
    .base_i    (base_i),
    .exp_i     (exp_i),
    .busy      (busy),
    .eoc       (eoc),
    .R_o       (R_o),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_done   (mm_done),
    .mm_result (mm_result)
  );

  // Multiplier stand-in: (a*b) mod 1009, done L cycles after start, frozen by en.
  int           pend = 0;
  logic [W-1:0] prod = '0;
  logic         inj = 1'b0;

  always @(posedge clk) begin
    if (en) begin
      if (mm_start) begin
        pend <= L;
        prod <= W'((32'(mm_a) * 32'(mm_b)) % MODN);
      end else if (pend > 0) begin
        pend <= pend - 1;
      end
    end
  end

  assign mm_done   = (pend == 1) | inj;
  assign mm_result = inj ? W'(341) : prod;

  // Event counters sampled mid-cycle.
  int n_start = 0, n_eq = 0, n_eoc = 0;
  always @(negedge clk) begin
    if (mm_start) n_start++;
    if (mm_start && (mm_a == mm_b)) n_eq++;
    if (eoc) n_eoc++;
  end

  // Reference: plain repeated multiplication, latency from the cycle rule.
  function automatic int ref_pow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % MODN;
    return r;
  endfunction

  function automatic int ref_lat(input int e);
    return 2 + (W + $countones(e)) * (L + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input int b, input int e, input bit stall, input bit abuse,
                        input string tag);
    int lat, s0, q0, e0, busy_bad;
    bit got;
    logic [W-1:0] r_keep;
    s0 = n_start; q0 = n_eq; e0 = n_eoc;
    busy_bad = 0; got = 0;
    @(posedge clk); #1;
    base_i = W'(b); exp_i = W'(e); start = 1'b1;
    @(posedge clk); #1;                  // start-sample edge
    start = 1'b0;
    lat = 0;
    if (!busy) busy_bad++;
    while (!got && lat < 600) begin
      @(posedge clk); #1;
      lat++;
      if (eoc) got = 1;
      else begin
        if (!busy) busy_bad++;
        if (abuse && lat == 1) begin
          chk({tag, "_sqrs_start"}, mm_start, 1);
          inj = 1'b1; start = 1'b1;
          base_i = ~W'(b); exp_i = ~W'(e);
        end
        if (abuse && lat == 2) begin
          inj = 1'b0; start = 1'b0;
        end
        if (stall && lat == 3) en = 1'b0;
        if (stall && lat == 8) en = 1'b1;
      end
    end
    chk({tag, "_eoc_seen"}, got, 1);
    chk({tag, "_lat"}, lat, ref_lat(e) + (stall ? 5 : 0));
    chk({tag, "_r"}, R_o, ref_pow(b, e));
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_nstart"}, n_start - s0, W + $countones(e));
    if (e == 0) chk({tag, "_sq_only"}, n_eq - q0, W);
    r_keep = R_o;
    @(posedge clk); #1;
    chk({tag, "_eoc_1cyc"}, eoc, 0);
    chk({tag, "_r_hold"}, R_o, r_keep);
    chk({tag, "_neoc"}, n_eoc - e0, 1);
  endtask

  initial begin
    int k, e0, b, e;
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_eoc", eoc, 0);
    chk("rst_mmstart", mm_start, 0);
    chk("rst_r", R_o, 0);
    rstb = 1'b1;

    run_op(5, 3, 0, 0, "basic");
    run_op(7, 0, 0, 0, "zero_exp");
    run_op(2, 10, 0, 0, "wrap");
    run_op(5, 3, 1, 0, "stall");
    run_op(5, 3, 0, 1, "abuse");
    run_op(1008, 1023, 0, 0, "maxexp");

    for (int i = 0; i < 8; i++) begin
      b = int'($urandom_range(MODN - 1));
      e = int'($urandom_range((1 << W) - 1));
      run_op(b, e, 0, 0, $sformatf("rnd%0d", i));
    end

    // Reset while waiting on a multiply.
    @(posedge clk); #1;
    base_i = W'(5); exp_i = W'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(mm_start && mm_a != mm_b) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midrst_found_mul", (k < 200), 1);
    @(posedge clk); #1;
    chk("midrst_in_mulw", busy, 1);
    rstb = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_r", R_o, 0);
    chk("midrst_eoc", eoc, 0);
    e0 = n_eoc;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_eoc", n_eoc - e0, 0);
    chk("midrst_idle", busy, 0);
    run_op(3, 4, 0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Sequences MSB-first square-and-multiply modular exponentiation R = B^E mod N over a shared modular multiplier.
- Owns the accumulator and the exponent-bit scanner, and issues start/done handshakes to the multiplier.
- Emits a one-cycle eoc pulse with the result, for capture by the downstream result register (en/eoc interface).
- Sits between the top-level register file (B, E, start) and the multiplier / result-register pair.

Parameters:
- WIDTH, 10, operand/exponent/result width in bits.
- CNT_W, 4, width of bit-index counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rstb  input  1  reset, synchronous, active-low.
- en  input  1  global advance enable; low freezes all state.
- start  input  1  request pulse; sampled only in IDLE.
- base_i  input  WIDTH  base B, already reduced mod N.
- exp_i  input  WIDTH  exponent E.
- busy  output  1  high in every state except IDLE.
- eoc  output  1  one-cycle end-of-computation pulse.
- R_o  output  WIDTH  result; valid when eoc=1, held afterwards.
- mm_start  output  1  one-cycle multiplier start.
- mm_a  output  WIDTH  multiplier operand A (always acc).
- mm_b  output  WIDTH  multiplier operand B: acc for square, base for multiply.
- mm_done  input  1  multiplier completion strobe.
- mm_result  input  WIDTH  multiplier product, valid with mm_done.

Behaviour:
- Reset (rstb=0 at a rising clk edge, synchronous, overrides en): state=IDLE, busy=0, eoc=0, mm_start=0, R_o=0, acc=0, base and exp registers=0, bit index=0.
- Reset mid-operation: abort immediately, no eoc; any later mm_done is ignored in IDLE.
- en=0: state and registers hold; mm_start and eoc forced 0. Pulses resume when en returns to 1.
- IDLE: on start=1 (with en=1), latch base_i and exp_i, set acc=1 and idx=WIDTH-1, go to LOAD. start in any other state is ignored.
- LOAD: one cycle, then go to SQR_S.
- SQR_S: mm_start=1, mm_b=acc, go to SQR_W. mm_done in a START state is ignored.
- SQR_W: on mm_done, acc<=mm_result.
  - If exp[idx]=1, go to MUL_S.
  - Else if idx==0, go to DONE.
  - Else idx<=idx-1 and go to SQR_S.
- MUL_S: mm_start=1, mm_b=base, go to MUL_W.
- MUL_W: on mm_done, acc<=mm_result.
  - If idx==0, go to DONE.
  - Else idx<=idx-1 and go to SQR_S.
- DONE: eoc=1 for exactly one cycle, R_o<=acc on the same edge, then go to IDLE. R_o holds until the next DONE or reset.
- mm_a=acc in all states; mm_b=acc except in MUL_S/MUL_W, where mm_b=base.
- Timing: with multiplier latency L (done L cycles after start), each operation takes L+1 cycles.
- Latency: eoc asserts 2 + (WIDTH + popcount(E))*(L+1) cycles after the start-sample edge. There is no leading-zero skipping, so latency is constant per popcount.
- E=0: WIDTH squarings of 1, R_o=1.
- idx never wraps: a decrement occurs only when idx>0.

Decomposition:
- Package rsa_pkg: state enum (IDLE, LOAD, SQR_S, SQR_W, MUL_S, MUL_W, DONE), operand-select constants (SEL_ACC, SEL_BASE), default WIDTH.
- Sub-module rsa_bit_scan: holds the exponent shift/index counter; provides cur_bit and last_bit; load/dec controls.
- FSM and acc remain in the top module.

Test Plan:
- Bench model: WIDTH=10, multiplier computes (a*b) mod 1009 with L=3.
- Basic: base=5, exp=3 -> R_o=125; eoc at cycle 2+12*4=50 after the start edge; busy high throughout, exactly one eoc pulse.
- Zero exponent: base=7, exp=0 -> R_o=1 after 42 cycles; exactly 10 mm_start pulses, all with mm_b=acc.
- Wrap past modulus: base=2, exp=10 -> R_o=15 (1024 mod 1009); exactly 2 MUL operations observed.
- Stall: hold en=0 for 5 cycles during SQR_W of base=5, exp=3 -> same R_o=125, eoc delayed by exactly 5 cycles, no extra mm_start.
- Protocol abuse: start pulsed while busy -> ignored, inputs not relatched; mm_done asserted in SQR_S -> ignored; result is unchanged.
- Reset mid-op: rstb=0 for one cycle during MUL_W -> next cycle state=IDLE, busy=0, R_o=0, no eoc; a following start with base=3, exp=4 -> R_o=81.
